// File: rtl/data_derotator_if.sv
// Handshake/config/output bundle for data_derotator.
// DI channel: a column word moves when DI_valid and DI_ready are both high at a
// rising clk edge; DI_valid is not withdrawn by the block, DI_ready only reflects
// whether the block is collecting. DO has no ready: a rebuilt row is presented
// for one cycle with DO_valid high and must be taken by the consumer.
interface data_derotator_if #(
   parameter int WORD_SIZE = 128
);
   logic                 config_valid;
   logic [2:0]           op;
   logic [4:0]           channel;
   logic                 DI_valid;
   logic [WORD_SIZE-1:0] DI;
   logic                 DI_ready;
   logic                 DO_valid;
   logic [WORD_SIZE-1:0] DO;
   logic                 DO_last;
   logic                 state_dbg;

   modport master (
      output config_valid, op, channel, DI_valid, DI,
      input  DI_ready, DO_valid, DO, DO_last, state_dbg
   );

   modport slave (
      input  config_valid, op, channel, DI_valid, DI,
      output DI_ready, DO_valid, DO, DO_last, state_dbg
   );
endinterface

// File: rtl/data_derotator.sv
// Byte-matrix transposer: collects up to MAX_CH column words, each carrying one
// byte per lane in its upper LANES bytes, then drains LANES rebuilt row words.
// Unused column positions of each row stay zero, so rows are zero-padded low.
module data_derotator #(
   parameter int WORD_SIZE = 128,
   parameter int LANES     = 8,
   parameter int MAX_CH    = WORD_SIZE / 8
) (
   input logic            clk,
   input logic            rst,
   data_derotator_if.slave bus
);
   localparam int CW = $clog2(MAX_CH);
   localparam int RW = $clog2(LANES);

   typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

   state_t               state;
   logic [4:0]           channel_reg;
   logic [CW-1:0]        col;
   logic [RW-1:0]        row;
   logic [WORD_SIZE-1:0] row_buf [LANES];
   logic [WORD_SIZE-1:0] do_q;
   logic                 do_valid_q;
   logic                 do_last_q;
   logic                 cfg_ok;

   // Config only lands between blocks, with no data competing for the cycle.
   assign cfg_ok = bus.config_valid && (bus.op == 3'b000) && (state == COLLECT) &&
                   (col == '0) && !bus.DI_valid &&
                   (bus.channel != 5'd0) && (bus.channel <= 5'(MAX_CH));

   assign bus.DI_ready  = (state == COLLECT);
   assign bus.DO_valid  = do_valid_q;
   assign bus.DO        = do_q;
   assign bus.DO_last   = do_last_q;
   assign bus.state_dbg = state;

   // Collect/drain FSM with all buffer and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= COLLECT;
         channel_reg <= 5'd1;
         col         <= '0;
         row         <= '0;
         do_q        <= '0;
         do_valid_q  <= 1'b0;
         do_last_q   <= 1'b0;
         for (int j = 0; j < LANES; j++) row_buf[j] <= '0;
      end else begin
         case (state)
            COLLECT: begin
               do_valid_q <= 1'b0;
               do_last_q  <= 1'b0;
               if (bus.DI_valid) begin
                  // Lane j byte of the column lands in row j at column position col.
                  for (int j = 0; j < LANES; j++)
                     row_buf[j][WORD_SIZE-1-8*int'(col) -: 8] <= bus.DI[WORD_SIZE-1-8*j -: 8];
                  if (5'(col) == channel_reg - 5'd1) begin
                     col   <= '0;
                     row   <= '0;
                     state <= DRAIN;
                  end else begin
                     col <= col + 1'b1;
                  end
               end else if (cfg_ok) begin
                  channel_reg <= bus.channel;
               end
            end
            DRAIN: begin
               do_q       <= row_buf[row];
               do_valid_q <= 1'b1;
               do_last_q  <= (row == RW'(LANES - 1));
               row        <= row + 1'b1;
               if (row == RW'(LANES - 1)) begin
                  // DO takes the pre-clear row; buffer starts the next block empty.
                  state <= COLLECT;
                  for (int j = 0; j < LANES; j++) row_buf[j] <= '0;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end
endmodule

// File: tb/tb_data_derotator.sv
// Directed bench for data_derotator: hand-built column words, expected rows
// queued ahead of each drain and compared one by one as they appear on DO.
module tb_data_derotator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   low_cnt;
   logic [127:0] exp_q[$];

   data_derotator_if #(.WORD_SIZE(128)) bus ();

   data_derotator #(.WORD_SIZE(128), .LANES(8), .MAX_CH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Column c of a block: lane j byte = base + 16j + c, low half is junk.
   function automatic logic [127:0] mk_col(input int base, input int c, input logic [63:0] junk);
      logic [127:0] v;
      v = '0;
      for (int j = 0; j < 8; j++) v[127-8*j -: 8] = 8'(base + 16*j + c);
      v[63:0] = junk;
      return v;
   endfunction

   // Row j of a block with n columns: bytes base+16j+k for k < n, zeros below.
   function automatic logic [127:0] mk_row(input int base, input int j, input int n);
      logic [127:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v[127-8*k -: 8] = 8'(base + 16*j + k);
      return v;
   endfunction

   task automatic send_col(input logic [127:0] data);
      int n;
      n = 0;
      while (!bus.DI_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL di_ready_timeout: got 0 want 1");
      end
      bus.DI_valid = 1'b1;
      bus.DI       = data;
      tick();
      bus.DI_valid = 1'b0;
   endtask

   task automatic send_cfg(input logic [2:0] op, input logic [4:0] ch);
      bus.config_valid = 1'b1;
      bus.op           = op;
      bus.channel      = ch;
      tick();
      bus.config_valid = 1'b0;
   endtask

   // Called one step after the last-column edge; returns one step after the row-7 edge.
   task automatic drain(output int lows);
      logic [127:0] e;
      lows = 0;
      check("pre_drain_valid", {127'b0, bus.DO_valid}, 128'd0);
      for (int r = 0; r < 8; r++) begin
         if (!bus.DI_ready) lows++;
         tick();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
         check("drain_valid", {127'b0, bus.DO_valid}, 128'd1);
         check("drain_row", bus.DO, e);
         check("drain_last", {127'b0, bus.DO_last}, (r == 7) ? 128'd1 : 128'd0);
      end
      if (!bus.DI_ready) lows++;
      check("post_drain_ready", {127'b0, bus.DI_ready}, 128'd1);
   endtask

   initial begin
      bus.config_valid = 1'b0;
      bus.op           = 3'b000;
      bus.channel      = 5'd0;
      bus.DI_valid     = 1'b0;
      bus.DI           = '0;

      // Reset state
      repeat (3) tick();
      check("rst_do", bus.DO, 128'd0);
      check("rst_do_valid", {127'b0, bus.DO_valid}, 128'd0);
      check("rst_do_last", {127'b0, bus.DO_last}, 128'd0);
      rst = 1'b0;
      tick();
      check("rst_ready", {127'b0, bus.DI_ready}, 128'd1);
      check("rst_state", {127'b0, bus.state_dbg}, 128'd0);

      // Default single-column block
      for (int r = 0; r < 8; r++) exp_q.push_back({8'(r), 120'd0});
      send_col({64'h0001020304050607, 64'hFFFF_FFFF_FFFF_FFFF});
      drain(low_cnt);
      tick();
      check("idle_valid", {127'b0, bus.DO_valid}, 128'd0);
      check("idle_do_hold", bus.DO, {8'h07, 120'd0});

      // Full 16-column block: row j = bytes 16j..16j+15
      send_cfg(3'b000, 5'd16);
      for (int j = 0; j < 8; j++) exp_q.push_back(mk_row(0, j, 16));
      for (int c = 0; c < 16; c++) send_col(mk_col(0, c, 64'(c) * 64'h0101_0101_0101_0101));
      drain(low_cnt);
      check("row0_full", mk_row(0, 0, 16), 128'h000102030405060708090A0B0C0D0E0F);

      // 3-column block with DI_valid held through the drain window
      send_cfg(3'b000, 5'd3);
      for (int j = 0; j < 8; j++) exp_q.push_back(mk_row(8'h80, j, 3));
      for (int c = 0; c < 3; c++) send_col(mk_col(8'h80, c, 64'h0));
      bus.DI_valid = 1'b1;
      bus.DI       = {128{1'b1}};
      drain(low_cnt);
      bus.DI_valid = 1'b0;
      check("ready_low_cycles", 128'(low_cnt), 128'd8);
      for (int j = 0; j < 8; j++) exp_q.push_back(mk_row(0, j, 3));
      for (int c = 0; c < 3; c++) send_col(mk_col(0, c, 64'h5555));
      drain(low_cnt);

      // Config corners: bad channel values, wrong opcode, config beside data, config mid-block
      send_cfg(3'b000, 5'd0);
      send_cfg(3'b000, 5'd17);
      send_cfg(3'b001, 5'd1);
      bus.config_valid = 1'b1;
      bus.op           = 3'b000;
      bus.channel      = 5'd1;
      send_col(mk_col(8'h20, 0, 64'h0));
      bus.config_valid = 1'b0;
      check("cfg_with_data_ready", {127'b0, bus.DI_ready}, 128'd1);
      send_col(mk_col(8'h20, 1, 64'h0));
      check("col1_ready", {127'b0, bus.DI_ready}, 128'd1);
      send_cfg(3'b000, 5'd1);
      check("cfg_mid_ready", {127'b0, bus.DI_ready}, 128'd1);
      for (int j = 0; j < 8; j++) exp_q.push_back(mk_row(8'h20, j, 3));
      send_col(mk_col(8'h20, 2, 64'h0));
      drain(low_cnt);

      // Reset during drain after row 2 has appeared
      for (int j = 0; j < 8; j++) exp_q.push_back(mk_row(8'h40, j, 3));
      for (int c = 0; c < 3; c++) send_col(mk_col(8'h40, c, 64'h0));
      for (int r = 0; r < 3; r++) begin
         tick();
         check("abort_row", bus.DO, exp_q.pop_front());
      end
      rst = 1'b1;
      #1;
      check("abort_valid", {127'b0, bus.DO_valid}, 128'd0);
      check("abort_do", bus.DO, 128'd0);
      check("abort_ready", {127'b0, bus.DI_ready}, 128'd1);
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         tick();
         check("post_abort_quiet", {127'b0, bus.DO_valid}, 128'd0);
      end
      for (int r = 0; r < 8; r++) exp_q.push_back({8'(8'h10 + r), 120'd0});
      send_col({64'h1011121314151617, 64'h0});
      drain(low_cnt);

      // Back-to-back 2-column blocks, second block waiting during the first drain
      send_cfg(3'b000, 5'd2);
      for (int j = 0; j < 8; j++) exp_q.push_back(mk_row(8'h80, j, 2));
      send_col(mk_col(8'h80, 0, 64'h0));
      send_col(mk_col(8'h80, 1, 64'h0));
      bus.DI_valid = 1'b1;
      bus.DI       = mk_col(8'h08, 0, 64'h0);
      drain(low_cnt);
      tick();
      check("b2b_col0_taken", {127'b0, bus.DI_ready}, 128'd1);
      bus.DI = mk_col(8'h08, 1, 64'h0);
      for (int j = 0; j < 8; j++) exp_q.push_back(mk_row(8'h08, j, 2));
      tick();
      bus.DI_valid = 1'b0;
      drain(low_cnt);
      check("exp_q_empty", 128'(exp_q.size()), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/data_derotator.md
DATA_DEROTATOR -- requirements
Module: data_derotator

Interface
REQ-001 Parameter WORD_SIZE, default 128, data word width in bits; it SHALL equal `WORD_SIZE.
REQ-002 Parameter LANES, default 8, number of row words rebuilt per block.
REQ-003 Parameter MAX_CH, default 16, maximum column words per block; it SHALL equal WORD_SIZE/8.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 config_valid  input  1  config strobe.
REQ-007 op  input  3  config opcode; only 3'b000 (set channel) SHALL be acted on.
REQ-008 channel  input  5  column words per block; valid range is 1..16.
REQ-009 DI_valid  input  1  column word present.
REQ-010 DI  input  WORD_SIZE  column word; lane j byte is DI[127-8j -: 8] for j in 0..7; DI[63:0] SHALL be ignored.
REQ-011 DI_ready  output  1  block accepts DI this cycle.
REQ-012 DO_valid  output  1  DO holds a rebuilt row.
REQ-013 DO  output  WORD_SIZE  rebuilt row word.
REQ-014 DO_last  output  1  DO holds row 7 of the block.

Function
REQ-015 States SHALL be COLLECT and DRAIN; DI_ready SHALL be 1 exactly when the state is COLLECT.
REQ-016 The block SHALL hold channel_reg (5 bits), a column counter col (0..15), a row counter row (0..7), and buf[0..7] of WORD_SIZE bits.
REQ-017 A DI word SHALL be accepted only when DI_valid and DI_ready are both 1; DI_valid in DRAIN SHALL be ignored with no side effects.
REQ-018 On acceptance at column c = col, the block SHALL perform buf[j][127-8c -: 8] <= DI[127-8j -: 8] for every j in 0..7; all other buf bytes SHALL be unchanged.
REQ-019 On acceptance with col == channel_reg-1, the block SHALL set col <= 0, set row <= 0, and enter DRAIN; otherwise col <= col+1.
REQ-020 buf bytes for columns >= channel_reg SHALL remain 0, which makes the output zero-padded in the low bytes.
REQ-021 In DRAIN, each cycle SHALL perform DO <= buf[row] and DO_valid <= 1, with DO_last <= (row == 7) and row <= row+1.
REQ-022 Drain timing for the last-column edge E0:
  - rows 0..7 appear on DO after edges E1..E8;
  - DO_valid is high for exactly 8 consecutive cycles;
  - no backpressure is applied.
REQ-023 At the row-7 edge (E8), the state SHALL return to COLLECT and all buf words SHALL clear to 0 (DO captures the pre-clear value).
REQ-024 In COLLECT, DO_valid and DO_last SHALL be 0 and DO SHALL hold its last value.
REQ-025 Config SHALL be accepted only when config_valid=1, op=3'b000, state is COLLECT, col == 0, and DI_valid=0.
REQ-026 An accepted config SHALL perform channel_reg <= channel.
REQ-027 A config with channel == 0 or channel > 16 SHALL be ignored and channel_reg unchanged.
REQ-028 If DI_valid and config_valid are both 1 in the same cycle, data SHALL be accepted and config SHALL be ignored.
REQ-029 Config attempted mid-block (col != 0) or in DRAIN SHALL be ignored.
REQ-030 Latency from the last column accepted to row 0 on DO SHALL be 1 cycle; block throughput SHALL be channel_reg + 8 cycles.

Reset
REQ-031 While rst=1, the block SHALL set:
  - state = COLLECT, col = 0, row = 0, channel_reg = 1;
  - all buf = 0;
  - DO = 0, DO_valid = 0, DO_last = 0;
  - DI_ready SHALL therefore be 1 after release.
REQ-032 Reset asserted mid-COLLECT or mid-DRAIN SHALL abort the block immediately; no further DO_valid SHALL occur until a new full block is received.

Verification
REQ-033 After reset, send 1 column with DI[127:64]=64'h0001020304050607 and default channel=1 -> rows 0..7 on DO are 8'h00..8'h07 in [127:120], all lower bits 0, DO_last only on row 7.
REQ-034 Configure channel=16, then send 16 columns where column c lane j = 8'(16j+c) -> row j = bytes 16j..16j+15 MSB-first, i.e. row 0 = 128'h000102...0F.
REQ-035 Configure channel=3 and send 3 columns -> rows carry 3 bytes in [127:104] and zeros in [103:0]; DI_ready is low for exactly 8 cycles, and DI_valid held during that window is not consumed.
REQ-036 Config corner cases:
  - config_valid with channel=0 -> channel_reg stays at its prior value;
  - config with DI_valid=1 in the same cycle -> ignored, data accepted;
  - config at col=2 -> ignored.
REQ-037 Assert rst during DRAIN at row 3 -> DO_valid drops to 0 immediately; after release, channel_reg=1 and a new 1-column block drains correctly with an all-zero background in buf.
REQ-038 Send two back-to-back blocks with channel=2 -> the second block's first column is accepted in the cycle after the row-7 edge; its rows contain no bytes from the first block.
